// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read-side stream controller.
package fifo_rd_pkg;

  localparam int BUF_DEPTH       = 2;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_CNT_WIDTH   = 16;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_checker.sv
// Invariant checker for the read controller: buffered plus in-flight words never exceed the buffer depth.
module fifo_rd_checker
  import fifo_rd_pkg::*;
(
  input logic clk,
  input logic rst,
  input occ_t occ,
  input logic inflight
);

  // Each issued read must have a guaranteed buffer slot when it lands.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, occ} + {2'b00, inflight}) <= 3'd2));

endmodule

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry output buffer: captures FIFO read data at the tail, presents the head on the stream.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  m_valid
);

  logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic                  head_r;
  logic                  tail_r;
  occ_t                  occ_r;

  // Storage, pointers and occupancy; capture and pop together leave occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      head_r <= 1'b0;
      tail_r <= 1'b0;
      occ_r  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_r[tail_r] <= wr_data;
        tail_r        <= ~tail_r;
      end
      if (pop) begin
        head_r <= ~head_r;
      end
      case ({wr_en, pop})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign occ       = occ_r;
  assign head_data = mem_r[head_r];
  assign m_valid   = (occ_r != 2'd0);

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side controller: issues reads, hides the one-cycle read latency and streams words out.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  idle
);

  logic                  pop_s;
  logic                  inflight_r;
  logic                  fifo_r_en_s;
  logic                  m_valid_s;
  logic [DATA_WIDTH-1:0] m_data_s;
  logic [CNT_WIDTH-1:0]  rd_count_r;
  occ_t                  occ_s;
  occ_t                  used_s;

  assign pop_s  = m_valid_s & m_ready;
  assign used_s = occ_s + {1'b0, inflight_r};

  // Read issue: a slot freed by this cycle's pop may be reused immediately.
  always_comb begin
    fifo_r_en_s = 1'b0;
    if (rst) begin
      fifo_r_en_s = 1'b0;
    end else if (en && !fifo_empty) begin
      fifo_r_en_s = ((used_s - {1'b0, pop_s}) < occ_t'(BUF_DEPTH));
    end else begin
      fifo_r_en_s = 1'b0;
    end
  end

  // In-flight flag tracks the FIFO's registered read latency; counter tallies stream transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 1'b0;
      rd_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      inflight_r <= fifo_r_en_s;
      if (pop_s) begin
        rd_count_r <= rd_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (inflight_r),
    .wr_data   (fifo_rdata),
    .pop       (pop_s),
    .occ       (occ_s),
    .head_data (m_data_s),
    .m_valid   (m_valid_s)
  );

  fifo_rd_checker u_chk (
    .clk      (clk),
    .rst      (rst),
    .occ      (occ_s),
    .inflight (inflight_r)
  );

  assign fifo_r_en = fifo_r_en_s;
  assign m_valid   = m_valid_s;
  assign m_data    = m_data_s;
  assign rd_count  = rd_count_r;
  assign idle      = (occ_s == 2'd0) & ~inflight_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: FIFO behavioural model feeding the reader, scoreboard of issued words with issue times.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst, en, fifo_empty, m_ready;
  logic [7:0] fifo_rdata;
  logic       fifo_r_en, m_valid, idle;
  logic [7:0] m_data;
  logic [15:0] rd_count;
  logic       fifo_r_en4, m_valid4, idle4;
  logic [7:0] m_data4;
  logic [3:0] rd_count4;

  always #5 clk = ~clk;

  fifo_stream_reader dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rd_count(rd_count), .idle(idle)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en4),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .rd_count(rd_count4), .idle(idle4)
  );

  logic [7:0] fq[$];       // contents of the upstream FIFO
  logic [7:0] out_val[$];  // words read from the FIFO but not yet transferred
  int         out_cyc[$];  // cycle in which each of those reads was issued
  int cyc = 0;
  int xfers = 0;
  int ren_cnt = 0;
  int errors = 0;
  int checks = 0;
  int base_x, base_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the FIFO and scoreboard.
  task automatic step(input logic e, input logic rdy);
    logic       exp_valid, exp_ren, pop, issued;
    logic [7:0] v;
    int         outstanding;
    en = e;
    m_ready = rdy;
    fifo_empty = (fq.size() == 0);
    #1;
    outstanding = out_val.size();
    exp_valid = (outstanding > 0) && (out_cyc[0] <= cyc - 2);
    pop = exp_valid & rdy;
    exp_ren = e & !fifo_empty & ((outstanding - int'(pop)) < 2);
    chk("r_en", fifo_r_en, exp_ren);
    chk("r_en4", fifo_r_en4, exp_ren);
    chk("m_valid", m_valid, exp_valid);
    chk("m_valid4", m_valid4, exp_valid);
    chk("idle", idle, outstanding == 0);
    chk("idle4", idle4, outstanding == 0);
    chk("rd_count", rd_count, xfers % 65536);
    chk("rd_count4", rd_count4, xfers % 16);
    if (exp_valid) begin
      chk("m_data", m_data, out_val[0]);
      chk("m_data4", m_data4, out_val[0]);
    end
    issued = fifo_r_en && (fq.size() > 0);
    v = 8'h00;
    if (fifo_r_en) ren_cnt++;
    if (issued) begin
      v = fq.pop_front();
      out_val.push_back(v);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (pop) begin
      void'(out_val.pop_front());
      void'(out_cyc.pop_front());
      xfers++;
    end
    fifo_rdata = issued ? v : 8'($urandom);
    cyc++;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; m_ready = 1'b0; fifo_rdata = 8'h00;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    fifo_empty = 1'b0;
    @(posedge clk); #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_rd_count", rd_count, 16'h0000);
    chk("rst_idle", idle, 1'b1);
    chk("rst_r_en", fifo_r_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: three words at full rate, first valid two cycles after first read.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("t1_count", rd_count, 16'd3);
    chk("t1_idle", idle, 1'b1);
    chk("t1_reads", ren_cnt, 3);

    // Backpressure: 10 stalled cycles allow exactly two reads, then 8 words with no gaps.
    push_words(8);
    base_r = ren_cnt;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("t2_stall_reads", ren_cnt - base_r, 2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("t2_count", rd_count, 16'd11);
    chk("t2_idle", idle, 1'b1);

    // Alternating ready with continuous feed: half-rate throughput.
    push_words(60);
    base_x = xfers;
    for (int i = 0; i < 40; i++) step(1'b1, (i % 2) == 0);
    chk("t3_half_rate", xfers - base_x, 19);
    for (int i = 0; i < 60 && (fq.size() > 0 || out_val.size() > 0); i++) step(1'b1, 1'b1);
    chk("t3_drained", fq.size() + out_val.size(), 0);

    // Drop enable with one word buffered and one in flight.
    push_words(5);
    base_r = ren_cnt;
    base_x = xfers;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("t4_reads", ren_cnt - base_r, 2);
    chk("t4_xfers", xfers - base_x, 2);
    chk("t4_idle", idle, 1'b1);
    step(1'b0, 1'b1);
    chk("t4_no_reads", ren_cnt - base_r, 2);

    // Reset with two words outstanding.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_m_valid", m_valid, 1'b0);
    chk("t5_m_data", m_data, 8'h00);
    chk("t5_rd_count", rd_count, 16'h0000);
    chk("t5_idle", idle, 1'b1);
    chk("t5_r_en", fifo_r_en, 1'b0);
    out_val.delete(); out_cyc.delete(); fq.delete();
    xfers = 0;
    fifo_empty = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Counter wrap on the narrow instance after 17 transfers.
    push_words(17);
    for (int i = 0; i < 30 && (fq.size() > 0 || out_val.size() > 0); i++) step(1'b1, 1'b1);
    chk("t6_count16", rd_count, 16'd17);
    chk("t6_count4", rd_count4, 4'd1);

    // Randomised traffic, then bounded drain.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) push_words(int'($urandom_range(1, 4)));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 400 && (fq.size() > 0 || out_val.size() > 0); i++) step(1'b1, 1'b1);
    chk("rand_drained", fq.size() + out_val.size(), 0);
    chk("rand_idle", idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the synchronous FIFO. It pops words from the FIFO read port (`r_en`, `empty`, registered `data_out`), absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words on a valid/ready stream at full throughput. It sits between the FIFO and any downstream consumer, and it also provides a drained-word counter and an idle flag for the control logic.

## Interface
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `CNT_WIDTH`, 16: width of the drained-word counter.
- `clk`  in  1  the single clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  drain enable; while low, no new FIFO reads are issued.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_r_en`  out  1  FIFO read enable; combinational.
- `fifo_rdata`  in  DATA_WIDTH  FIFO `data_out`; valid in the cycle after a read.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_data`  out  DATA_WIDTH  stream data.
- `rd_count`  out  CNT_WIDTH  number of stream transfers completed.
- `idle`  out  1  high when the buffer is empty and no read is in flight.

## Operation
- Internal state:
  - 2-entry buffer, organised as head/tail pointers plus `occ` (0..2).
  - `inflight` flag: set in the cycle after `fifo_r_en` was high.
- Derived signals:
  - `pop = m_valid & m_ready`.
  - `used = occ + inflight`, range 0..2.
- Read issue: `fifo_r_en = en & !fifo_empty & (used - pop < 2)`. Every asserted `fifo_r_en` is therefore a real FIFO read, and `fifo_r_en` is never high while `fifo_empty` is high.
- Capture: when `inflight` is high, `fifo_rdata` is written to the buffer tail at the closing edge of that cycle.
- Stream side:
  - `m_valid = (occ != 0)`.
  - `m_data` is the head entry.
  - Data is taken in strict FIFO order.
  - `m_data` holds stable while `m_valid & !m_ready`.
- Capture and pop in the same cycle: `occ` is unchanged, and both pointers advance.
- `rd_count` increments on every `pop` and wraps modulo 2^CNT_WIDTH.
- `idle = (occ == 0) & !inflight`.
- Deasserting `en` stops new reads immediately. Any in-flight word still lands and buffered words still drain, so `idle` is reached without data loss.
- Overflow is impossible by construction. An assertion checks `occ + inflight <= 2`.
- Reset values: `occ` = 0, `inflight` = 0, pointers = 0, `m_valid` = 0, `m_data` = 0, `rd_count` = 0, `idle` = 1.
- `fifo_r_en` is 0 while `rst` is high.
- Reset mid-operation discards the in-flight word and all buffered words. The FIFO instance must be reset in the same window so that its pointers stay consistent.

## Timing
- `fifo_r_en` is high in cycle N. `fifo_rdata` is valid in cycle N+1. The word is visible on `m_valid`/`m_data` in cycle N+2. Latency is 2 cycles from read issue to stream.
- Throughput: 1 word/cycle sustained when `m_ready` is held high and the FIFO stays non-empty. In steady state `occ` = 1 and `inflight` = 1.
- Backpressure: with `m_ready` low, at most 2 reads are outstanding. `fifo_r_en` drops once `used` reaches 2 and resumes in the same cycle as the next `pop`.
- The combinational path `m_ready -> fifo_r_en` is allowed. There is no combinational path from `fifo_rdata` to any output.

## Structure
- Package `fifo_rd_pkg` holds:
  - `localparam BUF_DEPTH = 2`;
  - `typedef logic [1:0] occ_t`;
  - the default `DATA_WIDTH`/`CNT_WIDTH` constants, shared with the FIFO top.
- One sub-module, `fifo_rd_skid_buf`, implements the 2-entry buffer: it takes a write strobe and data, plus `pop`, and outputs `occ`, head data and `m_valid`. The top contains the issue logic, the `inflight` flag and `rd_count`.

## Test plan
- FIFO preloaded with 0x11, 0x22, 0x33; `en` = 1; `m_ready` = 1. Required response: `m_data` sequence 0x11, 0x22, 0x33 on consecutive cycles, first valid 2 cycles after the first `fifo_r_en`; then `rd_count` = 3 and `idle` = 1.
- FIFO holds 8 words; `m_ready` = 0 for 10 cycles, then 1. Required response: exactly 2 `fifo_r_en` pulses during the stall, `m_data` = first word stable throughout, then all 8 words delivered in order with no gaps.
- `m_ready` toggling 1/0 each cycle with a continuous FIFO feed. Required response: no word is lost or duplicated, 50% throughput, and the assertion never fires.
- Word in flight plus one buffered, then `en` dropped. Required response: no further `fifo_r_en`, both words delivered, `idle` = 1 two cycles later.
- `rst` pulsed while 2 words are outstanding. Required response: immediately `m_valid` = 0, `m_data` = 0 and `rd_count` = 0; after release, normal draining of new data.
- `CNT_WIDTH` = 4 with 17 transfers. Required response: `rd_count` wraps to 1.
